// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_ALIGN    = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FLT_CONFLICT = 2'd3;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus wait-state counter; oTc fires in the cycle whose increment would reach TIMEOUT,
// so the strobe is held for exactly TIMEOUT unacknowledged cycles.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iClr,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  input  logic         iEn,
  output logic         oTc
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_inc;

  assign w_inc = r_cnt + 1'b1;
  assign oTc   = iEn && (w_inc == W'(TIMEOUT));

  always_ff @(posedge iClk) begin
    if (iRst || iClr) r_cnt <= '0;
    else if (iLoad)   r_cnt <= iLoadVal;
    else if (iEn)     r_cnt <= w_inc;
  end
endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer: one fetch/load/store at a time over a req/ack bus,
// with registered read data, a one-cycle ready pulse and a sticky fault state.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRd,
  input  logic              iWr,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iWData,
  output logic              oRdy,
  output logic [DATA_W-1:0] oRData,
  output logic              oBusy,
  output logic              oFault,
  output logic [1:0]        oFaultCode,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [DATA_W-1:0] oMem_WData,
  output logic              oMem_Rd,
  output logic              oMem_Wr,
  input  logic              iMem_Ack,
  input  logic [DATA_W-1:0] iMem_RData
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            r_state, w_nxt;
  logic [ADDR_W-3:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd;
  logic [1:0]        r_code;
  logic              w_idle, w_acc, w_req, w_conf, w_mis, w_accept, w_tc;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_acc    = (r_state == ST_ACCESS);
  assign w_req    = iRd | iWr;
  assign w_conf   = iRd & iWr;
  assign w_mis    = (iAddr[1:0] != 2'b00);
  assign w_accept = w_idle && w_req && !w_conf && !w_mis;

  // Held clear while idle, so every access starts counting from zero.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .iClk     (iClk),
    .iRst     (iRst),
    .iClr     (w_idle),
    .iLoad    (1'b0),
    .iLoadVal ({CW{1'b0}}),
    .iEn      (w_acc && !iMem_Ack),
    .oTc      (w_tc)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_conf || (w_req && w_mis)) w_nxt = ST_FAULT;
                 else if (w_req)                 w_nxt = ST_ACCESS;
      ST_ACCESS: if (iMem_Ack)                   w_nxt = ST_DONE;
                 else if (w_tc)                  w_nxt = ST_FAULT;
      ST_DONE:                                   w_nxt = ST_IDLE;
      default:                                   w_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rd    <= 1'b0;
      r_code  <= FLT_NONE;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_addr  <= iAddr[ADDR_W-1:2];
        r_wdata <= iWData;
        r_rd    <= iRd;
      end
      if (w_idle && w_conf)              r_code <= FLT_CONFLICT;
      else if (w_idle && w_req && w_mis) r_code <= FLT_ALIGN;
      else if (w_acc && !iMem_Ack && w_tc) r_code <= FLT_TIMEOUT;
      if (w_acc && iMem_Ack && r_rd) r_rdata <= iMem_RData;
    end
  end

  assign oRdy       = (r_state == ST_DONE);
  assign oBusy      = !w_idle;
  assign oFault     = (r_state == ST_FAULT);
  assign oFaultCode = r_code;
  assign oRData     = r_rdata;
  assign oMem_Addr  = {r_addr, 2'b00};
  assign oMem_WData = r_wdata;
  assign oMem_Rd    = w_acc && r_rd;
  assign oMem_Wr    = w_acc && !r_rd;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a transaction-level reference checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          iClk = 1'b0, iRst = 1'b0, iRd = 1'b0, iWr = 1'b0, iMem_Ack = 1'b0;
  logic [AW-1:0] iAddr = '0;
  logic [DW-1:0] iWData = '0, iMem_RData = '0;
  logic          oRdy, oBusy, oFault, oMem_Rd, oMem_Wr;
  logic [1:0]    oFaultCode;
  logic [DW-1:0] oRData, oMem_WData;
  logic [AW-1:0] oMem_Addr;

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .iClk(iClk), .iRst(iRst), .iRd(iRd), .iWr(iWr), .iAddr(iAddr), .iWData(iWData),
    .oRdy(oRdy), .oRData(oRData), .oBusy(oBusy), .oFault(oFault), .oFaultCode(oFaultCode),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData), .oMem_Rd(oMem_Rd), .oMem_Wr(oMem_Wr),
    .iMem_Ack(iMem_Ack), .iMem_RData(iMem_RData)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0, n_mis = 0;
  int cnt_rd = 0, cnt_wr = 0, cnt_rdy = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: a pending transaction plus a count of unacknowledged bus cycles.
  bit          m_pend, m_done, m_fault, m_rd;
  int          m_waits;
  logic [1:0]  m_code;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  always @(posedge iClk) begin
    if (iRst) begin
      m_pend <= 0; m_done <= 0; m_fault <= 0; m_rd <= 0; m_waits <= 0;
      m_code <= 0; m_rdata <= '0; m_wdata <= '0; m_addr <= '0;
    end else if (m_fault) begin
      // terminal until reset
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_pend) begin
      if (iMem_Ack) begin
        m_pend <= 0; m_done <= 1;
        if (m_rd) m_rdata <= iMem_RData;
      end else if (m_waits + 1 == TMO) begin
        m_pend <= 0; m_fault <= 1; m_code <= 2;
      end else m_waits <= m_waits + 1;
    end else if (iRd && iWr) begin
      m_fault <= 1; m_code <= 3;
    end else if (iRd || iWr) begin
      if (iAddr[1:0] != 2'b00) begin
        m_fault <= 1; m_code <= 1;
      end else begin
        m_pend <= 1; m_rd <= iRd; m_addr <= iAddr & ~32'h3; m_wdata <= iWData; m_waits <= 0;
      end
    end
  end

  always @(negedge iClk) begin
    if (chk_en) begin
      chk("cycle_outputs",
          {oRdy, oBusy, oFault, oFaultCode, oMem_Rd, oMem_Wr, oRData, oMem_Addr, oMem_WData},
          {m_done, m_pend | m_done | m_fault, m_fault, m_code, m_pend & m_rd, m_pend & ~m_rd,
           m_rdata, m_addr, m_wdata});
      cnt_rd  <= cnt_rd + int'(oMem_Rd);
      cnt_wr  <= cnt_wr + int'(oMem_Wr);
      cnt_rdy <= cnt_rdy + int'(oRdy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #2;
  endtask

  task automatic do_reset();
    iRst = 1'b1; step(1); iRst = 1'b0;
  endtask

  initial begin
    int b_rd, b_wr, b_rdy;
    step(1);
    do_reset();
    chk_en = 1'b1;
    chk("reset_state", {oRdy, oBusy, oFault, oFaultCode, oMem_Rd, oMem_Wr, oRData, oMem_Addr, oMem_WData}, '0);

    // zero-wait read
    b_rd = cnt_rd; b_rdy = cnt_rdy;
    iRd = 1; iAddr = 32'h100; iMem_Ack = 1; iMem_RData = 32'hDEADBEEF;
    step(1); iRd = 0;
    chk("zw_strobe_first_cycle", {oMem_Rd, oMem_Addr}, {1'b1, 32'h100});
    step(1);
    chk("zw_rdy_two_after_req", oRdy, 1);
    step(1); iMem_Ack = 0;
    step(1);
    chk("zw_rdata", oRData, 32'hDEADBEEF);
    chk("zw_rd_cycles", cnt_rd - b_rd, 1);
    chk("zw_rdy_pulses", cnt_rdy - b_rdy, 1);

    // wait-state write, ack in the sixth strobe cycle
    b_wr = cnt_wr; b_rdy = cnt_rdy;
    iWr = 1; iAddr = 32'h204; iWData = 32'h12345678; iMem_RData = 32'hAAAA5555;
    step(1); iWr = 0; iWData = 32'h0;
    step(5);
    chk("ws_addr_data_held", {oMem_Wr, oMem_Addr, oMem_WData}, {1'b1, 32'h204, 32'h12345678});
    iMem_Ack = 1; step(1); iMem_Ack = 0;
    chk("ws_rdy_after_ack", oRdy, 1);
    step(2);
    chk("ws_wr_cycles", cnt_wr - b_wr, 6);
    chk("ws_rdy_pulses", cnt_rdy - b_rdy, 1);
    chk("ws_rdata_unchanged", oRData, 32'hDEADBEEF);

    // misaligned read, then requests ignored
    b_rd = cnt_rd; b_wr = cnt_wr;
    iRd = 1; iAddr = 32'h102;
    step(1); iRd = 0;
    chk("mis_fault", {oFault, oFaultCode}, {1'b1, 2'd1});
    iWr = 1; iAddr = 32'h0; step(3); iWr = 0;
    step(1);
    chk("mis_no_strobes", (cnt_rd - b_rd) + (cnt_wr - b_wr), 0);
    chk("mis_sticky", {oFault, oBusy, oFaultCode}, {1'b1, 1'b1, 2'd1});
    do_reset();

    // timeout with no ack, then a late ack
    b_rd = cnt_rd; b_rdy = cnt_rdy;
    iRd = 1; iAddr = 32'h40;
    step(1); iRd = 0;
    step(10);
    chk("tmo_rd_cycles", cnt_rd - b_rd, TMO);
    chk("tmo_code", {oFault, oFaultCode, oMem_Rd}, {1'b1, 2'd2, 1'b0});
    iMem_Ack = 1; step(2); iMem_Ack = 0;
    step(1);
    chk("tmo_late_ack_no_rdy", cnt_rdy - b_rdy, 0);
    do_reset();

    // conflict, then reset in the middle of an access
    iRd = 1; iWr = 1; iAddr = 32'h10;
    step(1); iRd = 0; iWr = 0;
    chk("conflict_code", {oFault, oFaultCode}, {1'b1, 2'd3});
    do_reset();
    b_rdy = cnt_rdy;
    iRd = 1; iAddr = 32'h80;
    step(1); iRd = 0;
    step(1);
    iRst = 1; iMem_Ack = 1; iMem_RData = 32'h55;
    step(1); iRst = 0;
    chk("rst_mid_access", {oRdy, oBusy, oFault, oFaultCode, oMem_Rd, oMem_Wr, oRData, oMem_Addr, oMem_WData}, '0);
    step(1); iMem_Ack = 0;
    step(1);
    chk("rst_pending_ack_ignored", {cnt_rdy - b_rdy, oRData}, {32'd0, 32'h0});

    // back-to-back reads with the request held through DONE
    b_rd = cnt_rd; b_rdy = cnt_rdy;
    iRd = 1; iMem_Ack = 1;
    iAddr = 32'h0; iMem_RData = 32'd1; step(3);
    chk("b2b_first", oRData, 32'd1);
    iAddr = 32'h4; iMem_RData = 32'd2; step(3);
    chk("b2b_second", oRData, 32'd2);
    iAddr = 32'h8; iMem_RData = 32'd3; step(2);
    iRd = 0; step(1); iMem_Ack = 0;
    step(1);
    chk("b2b_third", oRData, 32'd3);
    chk("b2b_rdy_pulses", cnt_rdy - b_rdy, 3);
    chk("b2b_rd_cycles", cnt_rd - b_rd, 3);

    step(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
